// File: rtl/aux_port_arbiter.sv
// aux_port_arbiter: round-robin share of the SDRAM controller's aux (tape) port
// between three level-request clients, with read-data return and timeout abort.
module aux_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [22:0] c0_addr,
    input  logic [7:0]  c0_din,
    output logic [7:0]  c0_dout,
    output logic        c0_ack,
    output logic        c0_err,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [22:0] c1_addr,
    input  logic [7:0]  c1_din,
    output logic [7:0]  c1_dout,
    output logic        c1_ack,
    output logic        c1_err,
    input  logic        c2_req,
    input  logic        c2_we,
    input  logic [22:0] c2_addr,
    input  logic [7:0]  c2_din,
    output logic [7:0]  c2_dout,
    output logic        c2_ack,
    output logic        c2_err,
    output logic [22:0] tape_addr,
    output logic [7:0]  tape_din,
    output logic        tape_wr,
    output logic        tape_rd,
    input  logic [7:0]  tape_dout,
    input  logic        tape_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
    state_t      r_state;
    logic [1:0]  r_last, r_grant;
    logic        r_we, r_ack_prev, r_rd, r_wr;
    logic [7:0]  r_timer;
    logic [2:0]  r_gap;
    logic [22:0] r_addr;
    logic [7:0]  r_din;
    logic [7:0]  r_dout [3];
    logic [2:0]  r_ack, r_err;
    logic [2:0]  w_req, w_we;
    logic [22:0] w_addr [3];
    logic [7:0]  w_din [3];
    logic [1:0]  w_p0, w_p1, w_gnt;

    assign w_req     = {c2_req, c1_req, c0_req};
    assign w_we      = {c2_we, c1_we, c0_we};
    assign w_addr[0] = c0_addr;
    assign w_addr[1] = c1_addr;
    assign w_addr[2] = c2_addr;
    assign w_din[0]  = c0_din;
    assign w_din[1]  = c1_din;
    assign w_din[2]  = c2_din;

    // Candidates in priority order after the last grant; r_last itself is lowest.
    assign w_p0  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_p1  = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
    assign w_gnt = w_req[w_p0] ? w_p0 : w_req[w_p1] ? w_p1 : r_last;

    assign tape_addr = r_addr;
    assign tape_din  = r_din;
    assign tape_rd   = r_rd;
    assign tape_wr   = r_wr;
    assign c0_dout   = r_dout[0];
    assign c1_dout   = r_dout[1];
    assign c2_dout   = r_dout[2];
    assign {c2_ack, c1_ack, c0_ack} = r_ack;
    assign {c2_err, c1_err, c0_err} = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last     <= 2'd2;
            r_grant    <= 2'd0;
            r_we       <= 1'b0;
            r_ack_prev <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_timer    <= '0;
            r_gap      <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_dout     <= '{default: 8'hFF};
            r_ack      <= '0;
            r_err      <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                IDLE: begin
                    r_ack_prev <= tape_ack;
                    if (|w_req) begin
                        r_grant <= w_gnt;
                        r_last  <= w_gnt;
                        r_we    <= w_we[w_gnt];
                        r_addr  <= w_addr[w_gnt];
                        r_din   <= w_din[w_gnt];
                        r_wr    <= w_we[w_gnt];
                        r_rd    <= !w_we[w_gnt];
                        r_timer <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    // A toggle in the final timer cycle still wins over the abort.
                    if (tape_ack != r_ack_prev) begin
                        r_rd           <= 1'b0;
                        r_wr           <= 1'b0;
                        r_ack_prev     <= tape_ack;
                        r_ack[r_grant] <= 1'b1;
                        if (!r_we) r_dout[r_grant] <= tape_dout;
                        r_state        <= IDLE;
                    end else if (r_timer == 8'(TIMEOUT - 1)) begin
                        r_rd           <= 1'b0;
                        r_wr           <= 1'b0;
                        r_err[r_grant] <= 1'b1;
                        r_gap          <= '0;
                        r_state        <= GAP;
                    end
                end
                default: begin
                    r_ack_prev <= tape_ack;
                    r_gap      <= r_gap + 3'd1;
                    if (r_gap == 3'd7) r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aux_port_arbiter.sv
// tb_aux_port_arbiter: directed scoreboard bench with a behavioural tape-port controller model.
module tb_aux_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [22:0] addr [3] = '{default: '0};
    logic [7:0]  din [3] = '{default: '0};
    logic [7:0]  dout [3];
    logic [2:0]  ack, err;
    logic [22:0] tape_addr;
    logic [7:0]  tape_din;
    logic        tape_wr, tape_rd;
    logic [7:0]  tape_dout = 8'h00;
    logic        tape_ack = 1'b0;

    typedef struct packed {
        logic [1:0] c;
        logic       err;
        logic       we;
        logic [7:0] rdata;
    } exp_t;
    exp_t q[$];

    int   n_vec = 0, n_err = 0, cyc = 0;
    int   model_dly = 0, tog_req = 0, tog_done = 0;
    logic model_en = 1'b0;
    logic [7:0] exp_dout [3] = '{default: 8'hFF};
    int   mon_c;
    exp_t mon_e;

    aux_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_din(din[0]),
        .c0_dout(dout[0]), .c0_ack(ack[0]), .c0_err(err[0]),
        .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_din(din[1]),
        .c1_dout(dout[1]), .c1_ack(ack[1]), .c1_err(err[1]),
        .c2_req(req[2]), .c2_we(we[2]), .c2_addr(addr[2]), .c2_din(din[2]),
        .c2_dout(dout[2]), .c2_ack(ack[2]), .c2_err(err[2]),
        .tape_addr(tape_addr), .tape_din(tape_din), .tape_wr(tape_wr), .tape_rd(tape_rd),
        .tape_dout(tape_dout), .tape_ack(tape_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Controller model: answers a held strobe model_dly cycles after first seeing it.
    always begin
        @(negedge clk);
        if (tog_req != tog_done) begin
            tape_ack = ~tape_ack;
            tog_done = tog_done + 1;
        end else if (model_en && reset_n && (tape_rd || tape_wr)) begin
            repeat (model_dly) @(negedge clk);
            if (model_en && reset_n) begin
                if (tape_rd) tape_dout = tape_addr[7:0] ^ 8'h1F;
                tape_ack = ~tape_ack;
                @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) exp_dout = '{default: 8'hFF};
        if (tape_rd && tape_wr) begin
            n_err++;
            $display("FAIL strobe_excl: tape_rd and tape_wr both high at cycle %0d", cyc);
        end
        if (|{ack, err}) begin
            mon_c = (ack[0] || err[0]) ? 0 : (ack[1] || err[1]) ? 1 : 2;
            check("one_pulse", $countones({ack, err}), 1);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: ack=%b err=%b with nothing outstanding", ack, err);
            end else begin
                mon_e = q.pop_front();
                check("pulse_client", mon_c, mon_e.c);
                check("pulse_is_err", err[mon_c], mon_e.err);
                if (ack[mon_c] && !mon_e.we) exp_dout[mon_c] = mon_e.rdata;
                for (int k = 0; k < 3; k++) check($sformatf("dout%0d", k), dout[k], exp_dout[k]);
            end
        end
    end

    task automatic do_access(input int c, input logic w, input logic [22:0] a, input logic [7:0] d,
                             input int dly, input logic en, input logic xerr,
                             output int rd_n, output int wr_n, output int t_s, output int t_d,
                             output logic [22:0] s_a, output logic [7:0] s_d);
        bit done = 0;
        rd_n = 0; wr_n = 0; t_s = -1; t_d = -1; s_a = '0; s_d = '0;
        model_dly = dly;
        model_en = en;
        q.push_back('{c: 2'(c), err: xerr, we: w, rdata: a[7:0] ^ 8'h1F});
        we[c] = w; addr[c] = a; din[c] = d; req[c] = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((tape_rd || tape_wr) && t_s < 0) begin
                t_s = cyc; s_a = tape_addr; s_d = tape_din;
            end
            rd_n += int'(tape_rd);
            wr_n += int'(tape_wr);
            if (ack[c] || err[c]) begin done = 1; t_d = cyc; end
        end
        req[c] = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL access_timeout: client %0d got no ack/err within 60 cycles", c);
        end
    endtask

    initial begin
        int rd_n, wr_n, ts, td, e_t, total;
        int cnt [3];
        logic [22:0] sa;
        logic [7:0] sd;
        repeat (3) @(negedge clk);
        check("rst_tape_rd", tape_rd, 0);
        check("rst_tape_wr", tape_wr, 0);
        check("rst_tape_addr", tape_addr, 0);
        check("rst_tape_din", tape_din, 0);
        check("rst_ack_err", {ack, err}, 0);
        for (int k = 0; k < 3; k++) check($sformatf("rst_dout%0d", k), dout[k], 8'hFF);
        reset_n = 1'b1;

        do_access(1, 0, 23'h012345, 8'h00, 7, 1, 0, rd_n, wr_n, ts, td, sa, sd);
        check("rd_span", rd_n, 8);
        check("rd_no_wr", wr_n, 0);
        check("rd_addr", sa, 23'h012345);
        check("rd_latency", td - ts, 8);

        do_access(0, 1, 23'h7FFFFF, 8'hC3, 3, 1, 0, rd_n, wr_n, ts, td, sa, sd);
        check("wr_addr", sa, 23'h7FFFFF);
        check("wr_din", sd, 8'hC3);
        check("wr_span", wr_n, 4);
        check("wr_no_rd", rd_n, 0);

        do_access(2, 0, 23'h000100, 8'h00, 0, 0, 1, rd_n, wr_n, ts, td, sa, sd);
        check("to_latency", td - ts, 16);
        e_t = td;
        repeat (2) @(negedge clk);
        tog_req++;
        do_access(2, 0, 23'h000200, 8'h00, 2, 1, 0, rd_n, wr_n, ts, td, sa, sd);
        check("gap_regrant", ts - e_t, 9);

        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0;
            addr[k] = 23'(16 * (k + 1));
            cnt[k] = 0;
        end
        for (int i = 0; i < 9; i++) q.push_back('{c: 2'(i % 3), err: 1'b0, we: 1'b0,
                                                  rdata: 8'(16 * (i % 3 + 1)) ^ 8'h1F});
        model_dly = 2;
        model_en = 1'b1;
        total = 0;
        req = 3'b111;
        for (int i = 0; i < 400 && total < 9; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (ack[k]) begin
                cnt[k]++;
                total++;
                if (cnt[k] == 3) req[k] = 1'b0;
            end
        end
        req = '0;
        check("fair_total", total, 9);
        for (int k = 0; k < 3; k++) check($sformatf("fair_cnt%0d", k), cnt[k], 3);

        do_access(1, 0, 23'h000040, 8'h00, 15, 1, 0, rd_n, wr_n, ts, td, sa, sd);
        check("edge_ack_latency", td - ts, 16);

        model_en = 1'b0;
        we[0] = 1'b0; addr[0] = 23'h000050; req[0] = 1'b1;
        for (int i = 0; i < 20 && !tape_rd; i++) @(negedge clk);
        check("rst_pre_strobe", tape_rd, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd", tape_rd, 0);
        check("mid_rst_addr", tape_addr, 0);
        check("mid_rst_dout1", dout[1], 8'hFF);
        check("mid_rst_pulses", {ack, err}, 0);
        if (!tape_ack) tog_req++;
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", {tape_rd, tape_wr}, 0);
        do_access(0, 0, 23'h000060, 8'h00, 4, 1, 0, rd_n, wr_n, ts, td, sa, sd);
        check("post_rst_latency", td - ts, 5);

        repeat (4) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
